// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - handshake bundle between fetch, decode_stage and its consumer
interface decode_stage_if #(
  parameter int IMMW = 8,
  parameter int RW   = 4
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [8:0]      in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [8:0]      out_instr;
  logic [RW-1:0]   out_reg0;
  logic [RW-1:0]   out_reg1;
  logic [IMMW-1:0] out_imm;
  logic            out_use_imm;
  logic            out_illegal;
  logic            pfx_pending;

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_reg0, out_reg1,
           out_imm, out_use_imm, out_illegal, pfx_pending
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_reg0, out_reg1,
           out_imm, out_use_imm, out_illegal, pfx_pending
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered 9-bit ISA decode stage with IMMX immediate prefix chaining
module decode_stage #(
  parameter int IMMW = 8,
  parameter int RW   = 4
) (
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave bus
);
  localparam int PW   = (IMMW > 4) ? IMMW - 4 : 1;
  localparam int MAXC = IMMW / 4 - 1;
  localparam int CW   = (MAXC > 0) ? $clog2(MAXC + 1) : 1;

  typedef enum logic {IDLE, PFX} pfx_state_t;
  pfx_state_t state, state_next;

  logic            fire, consume, is_pfx;
  logic [CW-1:0]   pfx_cnt;
  logic [IMMW-1:0] imm_full;
  logic [RW-1:0]   d_reg0, d_reg1;
  logic [IMMW-1:0] d_imm;
  logic            d_use_imm, d_illegal;

  assign bus.in_ready    = !bus.flush && (!bus.out_valid || bus.out_ready);
  assign fire            = bus.in_valid && bus.in_ready;
  assign consume         = fire && !is_pfx;
  assign bus.pfx_pending = (state == PFX);

  // Prefix register only exists when the immediate is wider than one chunk.
  generate
    if (IMMW > 4) begin : g_pfx
      logic [PW-1:0] pfx_reg;
      always_ff @(posedge clk) begin
        if (reset || bus.flush || consume) pfx_reg <= '0;
        else if (fire)                     pfx_reg <= PW'({pfx_reg, bus.in_instr[3:0]});
      end
      assign imm_full = {pfx_reg, bus.in_instr[3:0]};
    end else begin : g_no_pfx
      assign imm_full = bus.in_instr[3:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || bus.flush || consume) pfx_cnt <= '0;
    else if (fire && pfx_cnt != CW'(MAXC)) pfx_cnt <= pfx_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.flush)  state_next = IDLE;
    else if (fire)  state_next = is_pfx ? PFX : IDLE;
  end

  always_comb begin
    d_reg0    = '0;
    d_reg1    = '0;
    d_imm     = '0;
    d_use_imm = 1'b0;
    d_illegal = 1'b0;
    is_pfx    = 1'b0;
    casez (bus.in_instr)
      9'b00???????: begin
        d_reg0 = RW'(bus.in_instr[5:3]);
        d_reg1 = RW'(bus.in_instr[2:0]);
      end
      9'b01???????: begin
        d_reg0    = RW'(bus.in_instr[3:2]);
        d_reg1    = RW'(bus.in_instr[1:0]);
        d_use_imm = 1'b1;
      end
      9'b1000?????, 9'b10010????, 9'b11000????: begin
        d_imm     = imm_full;
        d_use_imm = 1'b1;
      end
      9'b101??????: d_reg0 = RW'(bus.in_instr[2:0]);
      9'b11001????: is_pfx = 1'b1;
      default:      d_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.out_instr   <= '0;
      bus.out_reg0    <= '0;
      bus.out_reg1    <= '0;
      bus.out_imm     <= '0;
      bus.out_use_imm <= 1'b0;
      bus.out_illegal <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (consume) begin
      bus.out_valid   <= 1'b1;
      bus.out_instr   <= bus.in_instr;
      bus.out_reg0    <= d_reg0;
      bus.out_reg1    <= d_reg1;
      bus.out_imm     <= d_imm;
      bus.out_use_imm <= d_use_imm;
      bus.out_illegal <= d_illegal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
